lpc_io_target: RTL and testbench

LPC I/O-cycle target engine for the board FPGA. It decodes host I/O read and write cycles on LFRAME#/LAD[3:0] that fall in a 32-byte I/O window. For writes, it issues a single-cycle register write (Addr/Wr/DataWrSW) to the LPC register file. For reads, it returns the register file's selected byte to the host through the SYNC and data phases.

---
 rtl/lpc_io_target.sv | 148 ++++++++++++++
 tb/tb_lpc_io_target.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes host I/O reads/writes in a 32-byte window and bridges them to the register file.
// Write strobe issued on the SYNC clock; read data sampled on SYNC and returned on the next two clocks. No wait states.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h0800
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LFRAME_N,
    input  logic [3:0] LAD_IN,
    output logic [3:0] LAD_OUT,
    output logic       LAD_OE,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWrSW,
    input  logic [7:0] RdData
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        WDATA,
        HTAR,
        SYNC,
        RDATA,
        TTAR
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        dir_wr;
    logic [11:0] addr_sr;
    logic [3:0]  wr_lo;
    logic [7:0]  rd_buf;
    logic [15:0] io_addr;
    logic        match;

    // Full address as it will stand once the current nibble is shifted in.
    assign io_addr = {addr_sr, LAD_IN};
    assign match   = (io_addr[15:5] == BASE_ADDR[15:5]);

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            dir_wr   <= 1'b0;
            addr_sr  <= 12'h000;
            wr_lo    <= 4'h0;
            rd_buf   <= 8'h00;
            Addr     <= 8'h00;
            Wr       <= 1'b0;
            DataWrSW <= 8'h00;
        end else begin
            Wr <= 1'b0;
            if (!LFRAME_N) begin
                // Host framing wins in any state: a zero nibble starts a cycle, anything else aborts.
                state <= (LAD_IN == 4'h0) ? START : IDLE;
                cnt   <= 2'd0;
            end else begin
                case (state)
                    IDLE: ;
                    START: begin
                        cnt <= 2'd0;
                        case (LAD_IN)
                            4'h0: begin dir_wr <= 1'b0; state <= ADDR; end
                            4'h2: begin dir_wr <= 1'b1; state <= ADDR; end
                            default: state <= IDLE;
                        endcase
                    end
                    ADDR: begin
                        addr_sr <= io_addr[11:0];
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            cnt <= 2'd0;
                            if (match) begin
                                Addr  <= {3'b000, io_addr[4:0]};
                                state <= dir_wr ? WDATA : HTAR;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    WDATA: begin
                        if (cnt == 2'd0) begin
                            wr_lo <= LAD_IN;
                            cnt   <= 2'd1;
                        end else begin
                            // Commit the whole byte at once so an abort never leaves a half-written value.
                            DataWrSW <= {LAD_IN, wr_lo};
                            cnt      <= 2'd0;
                            state    <= HTAR;
                        end
                    end
                    HTAR: begin
                        if (cnt == 2'd0) begin
                            cnt <= 2'd1;
                        end else begin
                            cnt   <= 2'd0;
                            Wr    <= dir_wr;
                            state <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (!dir_wr) rd_buf <= RdData;
                        cnt   <= 2'd0;
                        state <= dir_wr ? TTAR : RDATA;
                    end
                    RDATA: begin
                        if (cnt == 2'd0) begin
                            cnt <= 2'd1;
                        end else begin
                            cnt   <= 2'd0;
                            state <= TTAR;
                        end
                    end
                    TTAR: begin
                        if (cnt == 2'd0) begin
                            cnt <= 2'd1;
                        end else begin
                            cnt   <= 2'd0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Pad drive depends on flops only, so LAD_IN/RdData never reach the pad combinationally.
    always_comb begin
        LAD_OE  = 1'b0;
        LAD_OUT = 4'hF;
        case (state)
            SYNC: begin
                LAD_OE  = 1'b1;
                LAD_OUT = 4'h0;
            end
            RDATA: begin
                LAD_OE  = 1'b1;
                LAD_OUT = cnt[0] ? rd_buf[7:4] : rd_buf[3:0];
            end
            TTAR: LAD_OE = ~cnt[0];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed bench for lpc_io_target: per-clock vector table of host inputs and expected target outputs.
module tb_lpc_io_target;

    logic       LpcClock = 1'b0;
    logic       PciReset;
    logic       LFRAME_N;
    logic [3:0] LAD_IN;
    logic [3:0] LAD_OUT;
    logic       LAD_OE;
    logic [7:0] Addr;
    logic       Wr;
    logic [7:0] DataWrSW;
    logic [7:0] RdData;

    lpc_io_target #(.BASE_ADDR(16'h0800)) dut (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .LFRAME_N (LFRAME_N),
        .LAD_IN   (LAD_IN),
        .LAD_OUT  (LAD_OUT),
        .LAD_OE   (LAD_OE),
        .Addr     (Addr),
        .Wr       (Wr),
        .DataWrSW (DataWrSW),
        .RdData   (RdData)
    );

    initial forever #5 LpcClock = ~LpcClock;

    typedef struct {
        logic       lf;
        logic [3:0] lad;
        logic [7:0] rd;
        logic       oe;
        logic [3:0] out;
        logic       wr;
        int         ea;   // expected Addr, -1 = don't care
        int         ed;   // expected DataWrSW, -1 = don't care
    } vec_t;

    vec_t tv[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic lf, input logic [3:0] lad, input logic [7:0] rd, input logic oe,
                       input logic [3:0] out, input logic wr, input int ea, input int ed);
        vec_t v;
        v.lf = lf; v.lad = lad; v.rd = rd; v.oe = oe; v.out = out; v.wr = wr; v.ea = ea; v.ed = ed;
        tv.push_back(v);
    endtask

    task automatic add_addr(input logic [15:0] a, input logic [7:0] rd);
        add(1'b1, a[15:12], rd, 1'b0, 4'hF, 1'b0, -1, -1);
        add(1'b1, a[11:8],  rd, 1'b0, 4'hF, 1'b0, -1, -1);
        add(1'b1, a[7:4],   rd, 1'b0, 4'hF, 1'b0, -1, -1);
        add(1'b1, a[3:0],   rd, 1'b0, 4'hF, 1'b0, -1, -1);
    endtask

    // Clocks 0..12 of an I/O write; m says whether the address lands in the window.
    task automatic add_write(input logic [15:0] a, input logic [7:0] d, input logic m, input int pa, input int pd);
        int ea;
        int ed;
        ea = m ? int'(a[4:0]) : pa;
        ed = m ? int'(d) : pd;
        add(1'b0, 4'h0, 8'h00, 1'b0, 4'hF, 1'b0, -1, -1);
        add(1'b1, 4'h2, 8'h00, 1'b0, 4'hF, 1'b0, -1, -1);
        add_addr(a, 8'h00);
        add(1'b1, d[3:0], 8'h00, 1'b0, 4'hF, 1'b0, -1, -1);
        add(1'b1, d[7:4], 8'h00, 1'b0, 4'hF, 1'b0, -1, -1);
        add(1'b1, 4'hF, 8'h00, 1'b0, 4'hF, 1'b0, ea, ed);
        add(1'b1, 4'hF, 8'h00, 1'b0, 4'hF, 1'b0, ea, ed);
        add(1'b1, 4'hF, 8'h00, m,    4'h0, m,    ea, ed);
        add(1'b1, 4'hF, 8'h00, m,    4'hF, 1'b0, ea, ed);
        add(1'b1, 4'hF, 8'h00, 1'b0, 4'hF, 1'b0, ea, ed);
    endtask

    // Clocks 0..12 of an in-window I/O read returning rd.
    task automatic add_read(input logic [15:0] a, input logic [7:0] rd);
        int ea;
        ea = int'(a[4:0]);
        add(1'b0, 4'h0, rd, 1'b0, 4'hF, 1'b0, -1, -1);
        add(1'b1, 4'h0, rd, 1'b0, 4'hF, 1'b0, -1, -1);
        add_addr(a, rd);
        add(1'b1, 4'hF, rd, 1'b0, 4'hF,    1'b0, ea, -1);
        add(1'b1, 4'hF, rd, 1'b0, 4'hF,    1'b0, ea, -1);
        add(1'b1, 4'hF, rd, 1'b1, 4'h0,    1'b0, ea, -1);
        add(1'b1, 4'hF, rd, 1'b1, rd[3:0], 1'b0, ea, -1);
        add(1'b1, 4'hF, rd, 1'b1, rd[7:4], 1'b0, ea, -1);
        add(1'b1, 4'hF, rd, 1'b1, 4'hF,    1'b0, ea, -1);
        add(1'b1, 4'hF, rd, 1'b0, 4'hF,    1'b0, ea, -1);
    endtask

    task automatic add_idle(input int n, input int ea, input int ed);
        for (int i = 0; i < n; i++) add(1'b1, 4'hF, 8'h00, 1'b0, 4'hF, 1'b0, ea, ed);
    endtask

    // Drive each vector just after the rising edge, check outputs at the falling edge of the same clock.
    task automatic run_table(input int n);
        for (int i = 0; i < n && i < tv.size(); i++) begin
            @(posedge LpcClock);
            #1;
            LFRAME_N = tv[i].lf;
            LAD_IN   = tv[i].lad;
            RdData   = tv[i].rd;
            @(negedge LpcClock);
            chk($sformatf("s%0d LAD_OE", step), LAD_OE, tv[i].oe);
            chk($sformatf("s%0d Wr", step), Wr, tv[i].wr);
            if (tv[i].oe) chk($sformatf("s%0d LAD_OUT", step), LAD_OUT, tv[i].out);
            if (tv[i].ea >= 0) chk($sformatf("s%0d Addr", step), Addr, tv[i].ea[7:0]);
            if (tv[i].ed >= 0) chk($sformatf("s%0d DataWrSW", step), DataWrSW, tv[i].ed[7:0]);
            step++;
        end
        tv.delete();
    endtask

    initial begin
        PciReset = 1'b1;
        LFRAME_N = 1'b1;
        LAD_IN   = 4'hF;
        RdData   = 8'h00;
        #1 PciReset = 1'b0;
        #2;
        chk("rst LAD_OE", LAD_OE, 1'b0);
        chk("rst LAD_OUT", LAD_OUT, 4'hF);
        chk("rst Addr", Addr, 8'h00);
        chk("rst Wr", Wr, 1'b0);
        chk("rst DataWrSW", DataWrSW, 8'h00);
        @(negedge LpcClock);
        @(negedge LpcClock);
        PciReset = 1'b1;

        add_idle(20, 0, 0);
        // Write then read back-to-back: the read's START follows TTAR clock 1 directly.
        add_write(16'h0808, 8'h5A, 1'b1, 0, 0);
        add_read(16'h0801, 8'h55);
        add_read(16'h0802, 8'hA3);
        // Rejected cycles leave Addr/DataWrSW untouched.
        add_write(16'h0820, 8'h11, 1'b0, 8'h02, 8'h5A);
        add(1'b0, 4'h0, 8'h00, 1'b0, 4'hF, 1'b0, 8'h02, 8'h5A);
        add(1'b1, 4'h4, 8'h00, 1'b0, 4'hF, 1'b0, 8'h02, 8'h5A);
        add_idle(10, 8'h02, 8'h5A);
        add_write(16'h081F, 8'h3C, 1'b1, 0, 0);
        run_table(1000);

        // Abort a write at clock 7, then a normal read.
        add(1'b0, 4'h0, 8'h00, 1'b0, 4'hF, 1'b0, -1, -1);
        add(1'b1, 4'h2, 8'h00, 1'b0, 4'hF, 1'b0, -1, -1);
        add_addr(16'h0809, 8'h00);
        add(1'b1, 4'h7, 8'h00, 1'b0, 4'hF, 1'b0, -1, 8'h3C);
        add(1'b0, 4'hF, 8'h00, 1'b0, 4'hF, 1'b0, -1, 8'h3C);
        add_idle(6, -1, 8'h3C);
        add_read(16'h0800, 8'hC6);
        run_table(1000);

        // Reset asserted during read data clock 9 must drop the pad immediately.
        add_read(16'h0803, 8'h9B);
        run_table(10);
        #2 PciReset = 1'b0;
        #1;
        chk("midrst LAD_OE", LAD_OE, 1'b0);
        chk("midrst Wr", Wr, 1'b0);
        chk("midrst LAD_OUT", LAD_OUT, 4'hF);
        LFRAME_N = 1'b1;
        LAD_IN   = 4'hF;
        @(negedge LpcClock);
        @(negedge LpcClock);
        chk("midrst Addr", Addr, 8'h00);
        chk("midrst LAD_OE hold", LAD_OE, 1'b0);
        PciReset = 1'b1;
        add_idle(2, 0, 0);
        add_write(16'h0805, 8'hE7, 1'b1, 0, 0);
        add_idle(3, 8'h05, 8'hE7);
        run_table(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
